// File: rtl/proc_cpu_debug_pkg.sv
// Shared types for the debug command dispatcher: action kinds, IR codes,
// FSM state encoding and the jdo -> action decode.
package proc_cpu_debug_pkg;

  typedef enum logic [3:0] {
    NONE           = 4'd0,
    OCIMEM_A       = 4'd1,
    OCIMEM_B       = 4'd2,
    NOACT_OCIMEM_A = 4'd3,
    BREAK_A        = 4'd4,
    BREAK_B        = 4'd5,
    BREAK_C        = 4'd6,
    NOACT_BREAK_A  = 4'd7,
    NOACT_BREAK_B  = 4'd8,
    NOACT_BREAK_C  = 4'd9,
    TRACECTRL      = 4'd10
  } action_kind_t;

  // IR codes, widened to 8 bits so any IR_W up to 8 compares cleanly.
  localparam logic [7:0] IR_OCIMEM = 8'd0;
  localparam logic [7:0] IR_STATUS = 8'd1;
  localparam logic [7:0] IR_BREAK  = 8'd2;
  localparam logic [7:0] IR_TRACE  = 8'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } dbg_state_t;

  // Map instruction + payload to the action a core's debug module performs.
  function automatic action_kind_t decode_kind(input logic [7:0] ir, input logic [37:0] d);
    action_kind_t k;
    k = NONE;
    case (ir)
      IR_OCIMEM: k = d[35] ? OCIMEM_B : (d[34] ? OCIMEM_A : NOACT_OCIMEM_A);
      IR_BREAK: begin
        if (!d[36])     k = d[37] ? BREAK_A : NOACT_BREAK_A;
        else if (!d[35]) k = d[37] ? BREAK_B : NOACT_BREAK_B;
        else            k = d[37] ? BREAK_C : NOACT_BREAK_C;
      end
      IR_TRACE:  k = d[15] ? TRACECTRL : NONE;
      IR_STATUS: k = NONE;
      default:   k = NONE;
    endcase
    return k;
  endfunction

  // Memory accesses are the only actions that must wait for the monitor.
  function automatic logic is_mem_kind(input action_kind_t k);
    return (k == OCIMEM_A) || (k == OCIMEM_B);
  endfunction

endpackage

// File: rtl/proc_cpu_debug_cmd_fifo.sv
// Show-ahead synchronous FIFO for queued debug commands; head is valid
// whenever empty is low so the dispatcher can pop and use it in one cycle.
module proc_cpu_debug_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy tracking; simultaneous push/pop keeps count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/proc_cpu_debug_cmd_dispatch.sv
// Debug command dispatcher: queues {ir, ch, data} commands, strobes one
// action per command at the addressed core, waits for memory actions to
// complete and returns one response per command.
// Optional feature: define DBG_TIMEOUT_EN to bound the wait-for-ready
// state to TIMEOUT_CYC cycles (expiry answers with an error response).
module proc_cpu_debug_cmd_dispatch
  import proc_cpu_debug_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int FW   = IR_W + CH_W + DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [IR_W-1:0]      cmd_ir,
  input  logic [CH_W-1:0]      cmd_ch,
  input  logic [DATA_W-1:0]    cmd_data,
  output logic                 act_valid,
  output logic [NUM_CH-1:0]    act_ch,
  output logic [3:0]           act_kind,
  output logic [DATA_W-1:0]    act_jdo,
  input  logic [NUM_CH-1:0]    ch_ready,
  input  logic [NUM_CH*32-1:0] ch_rdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [FW-1:0]     fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [IR_W-1:0]   head_ir;
  logic [CH_W-1:0]   head_ch;
  logic [DATA_W-1:0] head_data;
  logic [NUM_CH-1:0] head_onehot;
  logic              head_ch_ok;
  action_kind_t      head_kind;

  dbg_state_t        state_reg, state_next;
  action_kind_t      kind_reg;
  logic [NUM_CH-1:0] ch_onehot_reg;
  logic [DATA_W-1:0] jdo_reg;
  logic [31:0]       rsp_data_reg;
  logic              rsp_err_reg;
  logic [31:0]       rdata_masked [NUM_CH];
  logic [31:0]       sel_rdata;
  logic              sel_ready;
  logic              capture;
  logic              timed_out;

  proc_cpu_debug_cmd_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data ({cmd_ir, cmd_ch, cmd_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_ir, head_ch, head_data} = fifo_head;
  assign head_kind  = decode_kind(8'(head_ir), head_data[37:0]);
  assign head_ch_ok = |head_onehot;

  // Per-channel decode of the head index and masking of each core's read data.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign head_onehot[gi]  = (head_ch == CH_W'(gi));
    assign rdata_masked[gi] = ch_onehot_reg[gi] ? ch_rdata[gi*32 +: 32] : 32'd0;
  end

  // OR-reduce the masked read data of the held target core.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) sel_rdata = sel_rdata | rdata_masked[i];
  end

  assign sel_ready = |(ch_onehot_reg & ch_ready);

`ifdef DBG_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMR_W-1:0] timer_reg;

  // Wait-state down-counter, armed while the strobe is out.
  always_ff @(posedge clk) begin
    if (reset)                                timer_reg <= '0;
    else if (state_reg == ISSUE)              timer_reg <= TMR_W'(TIMEOUT_CYC - 1);
    else if (state_reg == WAIT && timer_reg != '0) timer_reg <= timer_reg - TMR_W'(1);
  end

  assign timed_out = (state_reg == WAIT) && !sel_ready && (timer_reg == '0);
`else
  assign timed_out = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic and FIFO pop; bad channels bypass ISSUE entirely.
  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = head_ch_ok ? ISSUE : RESP;
        end
      end
      ISSUE:   state_next = is_mem_kind(kind_reg) ? WAIT : RESP;
      WAIT:    if (sel_ready || timed_out) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read data is sampled as the strobe goes out for non-memory actions,
  // and on monitor completion for memory actions.
  assign capture = (state_reg == ISSUE && !is_mem_kind(kind_reg)) ||
                   (state_reg == WAIT && sel_ready);

  // Command holding registers and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      kind_reg      <= NONE;
      ch_onehot_reg <= '0;
      jdo_reg       <= '0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      if (fifo_pop) begin
        kind_reg      <= head_kind;
        ch_onehot_reg <= head_onehot;
        rsp_data_reg  <= '0;
        rsp_err_reg   <= !head_ch_ok;
        if (head_ch_ok) jdo_reg <= head_data;
      end
      if (capture)   rsp_data_reg <= sel_rdata;
      if (timed_out) rsp_err_reg  <= 1'b1;
    end
  end

  assign cmd_ready = !fifo_full;
  assign act_valid = (state_reg == ISSUE);
  assign act_ch    = act_valid ? ch_onehot_reg : '0;
  assign act_kind  = act_valid ? kind_reg : NONE;
  assign act_jdo   = jdo_reg;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_data  = rsp_valid ? rsp_data_reg : 32'd0;
  assign rsp_err   = rsp_valid && rsp_err_reg;
  assign busy      = (state_reg != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_proc_cpu_debug_cmd_dispatch.sv
// Self-checking bench for proc_cpu_debug_cmd_dispatch (5 cores, 4-deep FIFO).
// Honours DBG_TIMEOUT_EN for the wait-timeout scenario.
module tb_proc_cpu_debug_cmd_dispatch;

  localparam int NCH = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_ir;
  logic [2:0]   cmd_ch;
  logic [37:0]  cmd_data;
  logic         act_valid;
  logic [4:0]   act_ch;
  logic [3:0]   act_kind;
  logic [37:0]  act_jdo;
  logic [4:0]   ch_ready;
  logic [159:0] ch_rdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_data;
  logic         rsp_err;
  logic         busy;

  int checks = 0;
  int failures = 0;
  int act_count = 0;
  int rsp_count = 0;
  logic force_err = 1'b0;

  proc_cpu_debug_cmd_dispatch #(
    .NUM_CH(NCH), .DATA_W(38), .IR_W(2), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_ch(cmd_ch), .cmd_data(cmd_data),
    .act_valid(act_valid), .act_ch(act_ch), .act_kind(act_kind), .act_jdo(act_jdo),
    .ch_ready(ch_ready), .ch_rdata(ch_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Kind numbering: NONE0 OCIMEM_A1 OCIMEM_B2 NOACT_OCIMEM_A3 BREAK_A..C 4..6
  // NOACT_BREAK_A..C 7..9 TRACECTRL10; break variant index A=0,B=1,C=2.
  function automatic int model_kind(input logic [1:0] ir, input logic [37:0] d);
    int sel;
    case (ir)
      2'd0: return d[35] ? 2 : (d[34] ? 1 : 3);
      2'd2: begin
        sel = d[36] ? (d[35] ? 2 : 1) : 0;
        return d[37] ? 4 + sel : 7 + sel;
      end
      2'd3: return d[15] ? 10 : 0;
      default: return 0;
    endcase
  endfunction

  typedef struct { logic [4:0] ch; logic [3:0] kind; logic [37:0] jdo; } act_t;
  typedef struct { logic [31:0] data; logic err; } rsp_t;
  act_t exp_act[$];
  rsp_t exp_rsp[$];

  // Model: every accepted command yields one response; valid channels also one strobe.
  always @(posedge clk) begin
    act_t a;
    rsp_t r;
    int   chn;
    if (reset) begin
      exp_act.delete();
      exp_rsp.delete();
    end else if (cmd_valid && cmd_ready) begin
      chn = int'(cmd_ch);
      if (chn < NCH) begin
        a.ch   = 5'(1 << chn);
        a.kind = 4'(model_kind(cmd_ir, cmd_data));
        a.jdo  = cmd_data;
        exp_act.push_back(a);
        r.data = force_err ? 32'd0 : (32'hCAFE0000 + 32'(chn));
        r.err  = force_err;
      end else begin
        r.data = 32'd0;
        r.err  = 1'b1;
      end
      exp_rsp.push_back(r);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    act_t a;
    rsp_t r;
    #1;
    if (!reset) begin
      chk("busy", 64'(busy), 64'(exp_rsp.size() != 0));
      if (act_valid) begin
        act_count++;
        if (exp_act.size() == 0) chk("act_unexpected", 64'(act_valid), 64'd0);
        else begin
          a = exp_act.pop_front();
          chk("act_ch", 64'(act_ch), 64'(a.ch));
          chk("act_kind", 64'(act_kind), 64'(a.kind));
          chk("act_jdo", 64'(act_jdo), 64'(a.jdo));
        end
      end else begin
        chk("act_ch_idle", 64'(act_ch), 64'd0);
      end
      if (rsp_valid && rsp_ready) begin
        rsp_count++;
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        else begin
          r = exp_rsp.pop_front();
          chk("rsp_data", 64'(rsp_data), 64'(r.data));
          chk("rsp_err", 64'(rsp_err), 64'(r.err));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [1:0] ir, input logic [2:0] ch, input logic [37:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_ir = ir; cmd_ch = ch; cmd_data = d;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 64'(cmd_ready), 64'd1);
    $display("push ir=%0d ch=%0d data=%0h", ir, ch, d);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic take_rsp(output logic [31:0] d, output logic e);
    int n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrive", 64'(rsp_valid), 64'd1);
    d = rsp_data;
    e = rsp_err;
    $display("rsp data=%0h err=%0d", d, e);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", 64'(busy), 64'd0);
  endtask

  typedef struct { logic [1:0] ir; logic [2:0] ch; logic [37:0] d; } cmd_t;

  initial begin
    logic [31:0] d;
    logic        e;
    int          n;
    int          base;
    cmd_t        batch[4];
    cmd_t        mix[5];

    reset = 1'b1; cmd_valid = 1'b0; cmd_ir = '0; cmd_ch = '0; cmd_data = '0;
    rsp_ready = 1'b0; ch_ready = '0;
    for (int i = 0; i < NCH; i++) ch_rdata[i*32 +: 32] = 32'hCAFE0000 + 32'(i);
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_act_valid", 64'(act_valid), 64'd0);
    chk("rst_act_kind", 64'(act_kind), 64'd0);
    chk("rst_act_jdo", 64'(act_jdo), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: OCIMEM_A on ch1, monitor ready 3 cycles after the strobe.
    push(2'd0, 3'd1, 38'h04_0000_0123);
    chk("t1_act_early", 64'(act_valid), 64'd0);
    @(negedge clk);
    chk("t1_act_lat2", 64'(act_valid), 64'd1);
    chk("t1_act_ch", 64'(act_ch), 64'b00010);
    chk("t1_kind", 64'(act_kind), 64'd1);
    repeat (3) @(negedge clk);
    chk("t1_still_waiting", 64'(rsp_valid), 64'd0);
    ch_ready = 5'b00010;
    take_rsp(d, e);
    chk("t1_rsp_data", 64'(d), 64'hCAFE0001);
    chk("t1_rsp_err", 64'(e), 64'd0);
    ch_ready = 5'b11111;

    // 2: BREAK_C on ch0, response one cycle after the strobe.
    push(2'd2, 3'd0, 38'h38_0000_0055);
    @(negedge clk);
    chk("t2_act", 64'(act_valid), 64'd1);
    chk("t2_kind", 64'(act_kind), 64'd6);
    chk("t2_no_rsp_yet", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("t2_rsp_next", 64'(rsp_valid), 64'd1);
    take_rsp(d, e);
    chk("t2_rsp_data", 64'(d), 64'hCAFE0000);

    // 3: stall responses, fill the FIFO, then drain in order.
    push(2'd3, 3'd2, 38'h00_0000_8000);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("t3_blocker_resp", 64'(rsp_valid), 64'd1);
    batch[0] = '{2'd1, 3'd4, 38'h3F_FFFF_FFFF};
    batch[1] = '{2'd0, 3'd3, 38'h08_0000_0001};
    batch[2] = '{2'd2, 3'd0, 38'h30_0000_0002};
    batch[3] = '{2'd2, 3'd1, 38'h18_0000_0003};
    base = rsp_count;
    for (int i = 0; i < 4; i++) push(batch[i].ir, batch[i].ch, batch[i].d);
    chk("t3_full_after4", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1; cmd_ir = 2'd0; cmd_ch = 3'd4; cmd_data = 38'h00_0000_0004;
    repeat (3) @(negedge clk);
    chk("t3_fifth_blocked", 64'(cmd_ready), 64'd0);
    rsp_ready = 1'b1;
    push(2'd0, 3'd4, 38'h00_0000_0004);
    wait_idle();
    rsp_ready = 1'b0;
    chk("t3_rsp_count", 64'(rsp_count - base), 64'd6);

    // 4: out-of-range channels give error responses and no strobe.
    base = act_count;
    push(2'd1, 3'd7, 38'h00_0000_0777);
    take_rsp(d, e);
    chk("t4_err", 64'(e), 64'd1);
    chk("t4_data", 64'(d), 64'd0);
    push(2'd0, 3'd5, 38'h04_0000_0000);
    take_rsp(d, e);
    chk("t4b_err", 64'(e), 64'd1);
    chk("t4_no_strobe", 64'(act_count - base), 64'd0);

    // Remaining decode kinds, streamed with responses always accepted.
    mix[0] = '{2'd3, 3'd0, 38'h3F_FFFF_7FFF};
    mix[1] = '{2'd2, 3'd2, 38'h20_0000_0000};
    mix[2] = '{2'd2, 3'd3, 38'h00_0000_0000};
    mix[3] = '{2'd2, 3'd0, 38'h10_0000_0000};
    mix[4] = '{2'd0, 3'd1, 38'h0C_0000_0000};
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(mix[i].ir, mix[i].ch, mix[i].d);
    wait_idle();
    rsp_ready = 1'b0;

    // 5: monitor never ready.
    ch_ready = 5'b00000;
`ifdef DBG_TIMEOUT_EN
    force_err = 1'b1;
`endif
    push(2'd0, 3'd2, 38'h08_0000_0000);
    force_err = 1'b0;
    @(negedge clk);
    chk("t5_act", 64'(act_valid), 64'd1);
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge clk); if (!rsp_valid) n++; end
`ifdef DBG_TIMEOUT_EN
    chk("t5_timeout_cycles", 64'(n), 64'd16);
    take_rsp(d, e);
    chk("t5_err", 64'(e), 64'd1);
    chk("t5_data", 64'(d), 64'd0);
`else
    chk("t5_no_exit", 64'(rsp_valid), 64'd0);
    ch_ready = 5'b11111;
    take_rsp(d, e);
    chk("t5_data", 64'(d), 64'hCAFE0002);
    chk("t5_err", 64'(e), 64'd0);
`endif

    // 6: reset while waiting with two commands queued.
    ch_ready = 5'b00000;
    push(2'd0, 3'd1, 38'h04_0000_0001);
    push(2'd3, 3'd2, 38'h00_0000_8000);
    push(2'd1, 3'd3, 38'h00_0000_0000);
    @(negedge clk);
    chk("t6_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    reset = 1'b0;
    ch_ready = 5'b11111;
    repeat (4) @(negedge clk);
    chk("t6_stays_idle", 64'(busy), 64'd0);
    push(2'd1, 3'd3, 38'h00_0000_0042);
    take_rsp(d, e);
    chk("t6_recover_data", 64'(d), 64'hCAFE0003);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
